// File: rtl/seg7_hc595_scan.sv
// Scans an 8-digit seven-segment display through two cascaded 74HC595s.
// Frames arrive over valid/ready and swap into the display only at digit 0.
module seg7_hc595_scan #(
  parameter int unsigned CLK_DIV        = 5,
  parameter int unsigned SCAN_HOLD      = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        enable,
  output logic        seg7_SH_CP,
  output logic        seg7_ST_CP,
  output logic        seg7_DS,
  output logic [2:0]  digit_idx
);

  localparam int unsigned CntMax = (SCAN_HOLD > CLK_DIV) ? SCAN_HOLD : CLK_DIV;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(SCAN_HOLD - 1);

  typedef enum logic [2:0] {StLoad, StShLo, StShHi, StLatch, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     shreg_q, shreg_d;
  logic            ds_q, ds_d;
  logic            sh_q, sh_d;
  logic            st_q, st_d;
  logic [2:0]      digit_q, digit_d;
  logic [63:0]     active_q, active_d;
  logic [63:0]     pending_q, pending_d;
  logic            pend_full_q, pend_full_d;
  logic            ready_q, ready_d;

  logic [63:0]     active_sh;
  logic [7:0]      seg_byte;
  logic [7:0]      sel_byte;
  logic [15:0]     word;

  always_comb begin
    active_sh = active_q >> {digit_q, 3'b000};
    seg_byte  = (enable ? active_sh[7:0] : 8'h00) ^ {8{SEG_ACTIVE_LOW}};
    sel_byte  = (8'h01 << digit_q) ^ {8{DIG_ACTIVE_LOW}};
    word      = {seg_byte, sel_byte};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    ds_d        = ds_q;
    digit_d     = digit_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;

    if (frame_valid && ready_q) begin
      pending_d   = frame_data;
      pend_full_d = 1'b1;
    end

    unique case (state_q)
      StLoad: begin
        shreg_d = word;
        bit_d   = 4'd15;
        ds_d    = word[15];
        cnt_d   = '0;
        state_d = StShLo;
      end
      StShLo: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StShHi;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShHi: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (bit_q == 4'd0) begin
            state_d = StLatch;
          end else begin
            shreg_d = shreg_q << 1;
            ds_d    = shreg_q[14];
            bit_d   = bit_q - 4'd1;
            state_d = StShLo;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLatch: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          digit_d = digit_q + 3'd1;
          state_d = StLoad;
          // Frame swap only when wrapping back to digit 0, so no tearing.
          if (digit_q == 3'd7 && pend_full_q) begin
            active_d    = pending_q;
            pend_full_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase

    sh_d    = (state_d == StShHi);
    st_d    = (state_d == StLatch);
    // Ready drops with the capture, but rises a cycle after the swap.
    ready_d = ~(pend_full_q | pend_full_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      ds_q        <= 1'b0;
      sh_q        <= 1'b0;
      st_q        <= 1'b0;
      digit_q     <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      ds_q        <= ds_d;
      sh_q        <= sh_d;
      st_q        <= st_d;
      digit_q     <= digit_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      ready_q     <= ready_d;
    end
  end

  assign frame_ready = ready_q;
  assign seg7_SH_CP  = sh_q;
  assign seg7_ST_CP  = st_q;
  assign seg7_DS     = ds_q;
  assign digit_idx   = digit_q;

endmodule

// File: tb/tb_seg7_hc595_scan.sv
// Directed bench for seg7_hc595_scan: a negedge monitor decodes each shifted word
// and checks it against expected words queued by the stimulus sequence.
module tb_seg7_hc595_scan;

  localparam int ClkDiv   = 2;
  localparam int ScanHold = 10;
  localparam int SlotLen  = 1 + 33 * ClkDiv + ScanHold;
  localparam bit SegLow   = 1'b1;
  localparam bit DigLow   = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        enable;
  logic        sh_cp;
  logic        st_cp;
  logic        ds;
  logic [2:0]  digit_idx;

  always #5 clk = ~clk;

  seg7_hc595_scan #(
    .CLK_DIV       (ClkDiv),
    .SCAN_HOLD     (ScanHold),
    .SEG_ACTIVE_LOW(SegLow),
    .DIG_ACTIVE_LOW(DigLow)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .enable     (enable),
    .seg7_SH_CP (sh_cp),
    .seg7_ST_CP (st_cp),
    .seg7_DS    (ds),
    .digit_idx  (digit_idx)
  );

  int n_vec = 0;
  int n_err = 0;
  int latch_cnt = 0;
  logic [18:0] exp_q[$];

  // Bench-side model of the frame buffering.
  logic [63:0] m_active;
  logic [63:0] m_pending;
  logic        m_pend_full;
  logic        m_en;
  logic [2:0]  m_digit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [63:0] act, input logic [2:0] d,
                                             input logic en);
    logic [63:0] shifted;
    logic [7:0]  seg;
    logic [7:0]  sel;
    shifted = act >> (8 * d);
    seg = en ? shifted[7:0] : 8'h00;
    sel = 8'h01 << d;
    return {seg ^ {8{SegLow}}, sel ^ {8{DigLow}}};
  endfunction

  // Monitor: sample away from the rising edge.
  logic        sh_p, st_p, ds_p;
  logic [15:0] mon_word;
  logic [18:0] ent;
  int          rises, ds_stable, cyc, last_st, st_rise;
  bit          have_last;

  initial cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sh_p = 1'b0; st_p = 1'b0; ds_p = 1'b0;
      mon_word = '0; rises = 0; ds_stable = 0; have_last = 1'b0;
    end else begin
      if (ds !== ds_p) ds_stable = 0;
      else ds_stable++;
      if (sh_p && sh_cp) chk("ds_hold_while_sh_high", ds, ds_p);
      if (!sh_p && sh_cp) begin
        mon_word = {mon_word[14:0], ds};
        rises++;
        chk("ds_setup", (ds_stable >= ClkDiv), 1);
      end
      if (!st_p && st_cp) begin
        chk("sh_rises_per_latch", rises, 16);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $error("FAIL queue_empty: observed word 0x%0h, expected none pending", mon_word);
        end else begin
          ent = exp_q.pop_front();
          chk("word", mon_word, ent[15:0]);
          chk("digit_idx", digit_idx, ent[18:16]);
        end
        if (have_last) chk("slot_len", cyc - last_st, SlotLen);
        have_last = 1'b1;
        last_st   = cyc;
        st_rise   = cyc;
        rises     = 0;
        latch_cnt++;
      end
      if (st_p && !st_cp) chk("st_width", cyc - st_rise, ClkDiv);
      sh_p = sh_cp; st_p = st_cp; ds_p = ds;
    end
  end

  task automatic push_slot();
    if (m_digit == 3'd0 && m_pend_full) begin
      m_active    = m_pending;
      m_pend_full = 1'b0;
    end
    exp_q.push_back({m_digit, model_word(m_active, m_digit, m_en)});
  endtask

  task automatic wait_latch();
    int  target;
    bit  seen;
    target = latch_cnt + 1;
    seen   = 1'b0;
    for (int i = 0; i < 4 * SlotLen; i++) begin
      @(negedge clk);
      if (latch_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $error("FAIL latch_timeout: observed no ST_CP rise, expected one within %0d cycles",
             4 * SlotLen);
    end
    m_digit = m_digit + 3'd1;
  endtask

  task automatic run_slots(input int n);
    for (int i = 0; i < n; i++) begin
      push_slot();
      wait_latch();
    end
  endtask

  task automatic send_frame(input logic [63:0] f);
    logic exp_acc;
    exp_acc = ~m_pend_full;
    @(negedge clk);
    frame_data  = f;
    frame_valid = 1'b1;
    chk("ready_before_offer", frame_ready, exp_acc);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("ready_after_offer", frame_ready, 1'b0);
    if (exp_acc) begin
      m_pending   = f;
      m_pend_full = 1'b1;
    end
  endtask

  task automatic wait_digit(input logic [2:0] d, input logic need_sh);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * SlotLen; i++) begin
      @(negedge clk);
      if (digit_idx === d && (!need_sh || sh_cp === 1'b1)) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $error("FAIL digit_wait_timeout: observed digit %0d, expected %0d", digit_idx, d);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sh_cp"}, sh_cp, 1'b0);
    chk({tag, "_st_cp"}, st_cp, 1'b0);
    chk({tag, "_ds"}, ds, 1'b0);
    chk({tag, "_ready"}, frame_ready, 1'b1);
    chk({tag, "_digit"}, digit_idx, 3'd0);
  endtask

  localparam logic [63:0] F1 = 64'h0000_0000_0600_003F;
  localparam logic [63:0] F2 = 64'h6F7F_077D_6D66_4F5B;
  localparam logic [63:0] F4 = 64'h7177_7C39_5E79_7138;

  initial begin
    rst = 1'b1; enable = 1'b1; frame_valid = 1'b0; frame_data = '0;
    m_active = '0; m_pending = '0; m_pend_full = 1'b0; m_en = 1'b1; m_digit = 3'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Blank scan, then a frame offered while digit 5 is displayed.
    run_slots(6);
    send_frame(F1);
    send_frame(F2);
    send_frame(F2);
    run_slots(2);

    // Digit-0 slot takes the pending frame; ready returns a cycle after LOAD.
    push_slot();
    wait_digit(3'd0, 1'b0);
    chk("ready_during_swap_load", frame_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_swap_load", frame_ready, 1'b1);
    wait_latch();

    send_frame(F2);
    run_slots(8);

    // Blanking via enable, then resume.
    @(negedge clk);
    enable = 1'b0;
    m_en   = 1'b0;
    run_slots(3);
    @(negedge clk);
    enable = 1'b1;
    m_en   = 1'b1;
    run_slots(5);

    // Reset in SH_HI of digit 4 with a frame pending.
    send_frame(F4);
    run_slots(3);
    push_slot();
    wait_digit(3'd4, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_active = '0; m_pending = '0; m_pend_full = 1'b0; m_digit = 3'd0;
    run_slots(9);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
